// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - mode encoding, polynomial constants and checker state type
//
// Purpose: shared definitions for the PRBS generator/checker. The LFSR is
// always 31 bits wide; the selected polynomial only uses its low n bits.
// Ports: none (package).
package prbs_pkg;

  localparam int unsigned       LFSR_W    = 31;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,  // x^7  + x^6  + 1
    MODE_PRBS15 = 2'd1,  // x^15 + x^14 + 1
    MODE_PRBS23 = 2'd2,  // x^23 + x^18 + 1
    MODE_PRBS31 = 2'd3   // x^31 + x^28 + 1
  } prbs_mode_e;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // Bit index of the x^n term (n-1).
  function automatic logic [4:0] prbs_hi_idx(input logic [1:0] mode);
    case (mode)
      MODE_PRBS7:  return 5'd6;
      MODE_PRBS15: return 5'd14;
      MODE_PRBS23: return 5'd22;
      default:     return 5'd30;
    endcase
  endfunction

  // Bit index of the inner tap x^t (t-1).
  function automatic logic [4:0] prbs_tap_idx(input logic [1:0] mode);
    case (mode)
      MODE_PRBS7:  return 5'd5;
      MODE_PRBS15: return 5'd13;
      MODE_PRBS23: return 5'd17;
      default:     return 5'd27;
    endcase
  endfunction

  // Keeps only the low n bits so unused upper bits never hold stale data.
  function automatic logic [LFSR_W-1:0] prbs_mask(input logic [1:0] mode);
    case (mode)
      MODE_PRBS7:  return 31'h0000_007F;
      MODE_PRBS15: return 31'h0000_7FFF;
      MODE_PRBS23: return 31'h007F_FFFF;
      default:     return 31'h7FFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/prbs_step.sv
// rtl/prbs_step.sv - combinational W-bit advance of a Fibonacci LFSR
//
// Purpose: advances a 31-bit shift register by W bits for the selected
// polynomial. Bit W-1 is processed first. For every bit the feedback
// s[n-1]^s[t-1] is reported on fb_o; the bit shifted into s[0] is either that
// feedback (generator) or the external bit (self-synchronising checker).
// Ports:
//   mode    - polynomial select
//   state_i - current register contents
//   use_ext - 1: shift in ext_i bits, 0: shift in feedback
//   ext_i   - external bits, W-1 first
//   state_o - register contents after W bits
//   fb_o    - per-bit feedback (generated bits / checker expected bits)
module prbs_step
  import prbs_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]        mode,
  input  logic [LFSR_W-1:0] state_i,
  input  logic              use_ext,
  input  logic [W-1:0]      ext_i,
  output logic [LFSR_W-1:0] state_o,
  output logic [W-1:0]      fb_o
);

  logic [4:0]        hi_idx;
  logic [4:0]        tap_idx;
  logic [LFSR_W-1:0] mask;
  logic [LFSR_W-1:0] step_s;
  logic              step_fb;

  assign hi_idx  = prbs_hi_idx(mode);
  assign tap_idx = prbs_tap_idx(mode);
  assign mask    = prbs_mask(mode);

  always_comb begin
    step_s  = state_i & mask;
    step_fb = 1'b0;
    fb_o    = '0;
    for (int i = W - 1; i >= 0; i--) begin
      step_fb = step_s[hi_idx] ^ step_s[tap_idx];
      fb_o[i] = step_fb;
      step_s  = {step_s[LFSR_W-2:0], (use_ext ? ext_i[i] : step_fb)} & mask;
    end
    state_o = step_s;
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - parallel PRBS generator and self-synchronising checker
//
// Purpose: emits W bits of PRBS7/15/23/31 per enabled cycle and checks a
// received stream of the same polynomial, tracking lock and counting bit
// errors while locked.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous reset, active high (1 = in reset)
//   mode       - polynomial select (0..3 = PRBS7/15/23/31)
//   gen_en     - advance generator by W bits this cycle
//   inject_err - invert bit W-1 of the next emitted tx word
//   tx_data    - generated word, bit W-1 earliest
//   tx_valid   - tx_data holds a new word
//   rx_data    - received word, bit W-1 earliest
//   rx_valid   - rx_data qualifier
//   clr_cnt    - synchronous clear of err_cnt
//   locked     - checker is in LOCKED
//   err_flag   - last checked word had at least one bit error
//   err_cnt    - saturating errored-bit count accumulated while locked
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int W      = 8,
  parameter int CNT_W  = 16,
  parameter int SYNC_N = 16,
  parameter int LOSS_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             gen_en,
  input  logic             inject_err,
  output logic [W-1:0]     tx_data,
  output logic             tx_valid,
  input  logic [W-1:0]     rx_data,
  input  logic             rx_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SC_W  = $clog2(SYNC_N + 1);
  localparam int LC_W  = $clog2(LOSS_N + 1);
  localparam int PC_W  = $clog2(W + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [1:0]        mode_q, mode_d;
  logic [LFSR_W-1:0] gen_q, gen_d;
  logic [W-1:0]      tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              inj_pend_q, inj_pend_d;
  logic [LFSR_W-1:0] hist_q, hist_d;
  chk_state_e        state_q, state_d;
  logic [SC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [LC_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [LFSR_W-1:0] gen_next;
  logic [W-1:0]      gen_bits;
  logic [LFSR_W-1:0] hist_next;
  logic [W-1:0]      exp_bits;
  logic [W-1:0]      err_bits;
  logic [W-1:0]      inj_mask;
  logic [PC_W-1:0]   err_pop;
  logic [SUM_W-1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_sat;
  logic              word_err;
  logic              mode_chg;

  prbs_step #(.W(W)) u_gen_step (
    .mode    (mode),
    .state_i (gen_q),
    .use_ext (1'b0),
    .ext_i   ({W{1'b0}}),
    .state_o (gen_next),
    .fb_o    (gen_bits)
  );

  // Checker history is fed by the received bits, so it self-synchronises
  // once n clean bits have passed through it.
  prbs_step #(.W(W)) u_chk_step (
    .mode    (mode),
    .state_i (hist_q),
    .use_ext (1'b1),
    .ext_i   (rx_data),
    .state_o (hist_next),
    .fb_o    (exp_bits)
  );

  assign mode_chg = (mode != mode_q);

  // Generator: a mode change wins over gen_en and reseeds with all ones, so
  // the register can never reach the all-zero lock-up state.
  always_comb begin
    mode_d     = mode;
    gen_d      = gen_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    inj_pend_d = inj_pend_q | inject_err;
    inj_mask   = '0;
    inj_mask[W-1] = inj_pend_q | inject_err;
    if (mode_chg) begin
      gen_d = LFSR_SEED;
    end else if (gen_en) begin
      gen_d      = gen_next;
      tx_data_d  = gen_bits ^ inj_mask;
      tx_valid_d = 1'b1;
      inj_pend_d = 1'b0;
    end
  end

  // Error popcount and saturating sum, computed wide enough that the
  // compare against the maximum can never wrap.
  always_comb begin
    err_bits = rx_data ^ exp_bits;
    word_err = |err_bits;
    err_pop  = '0;
    for (int i = 0; i < W; i++) begin
      err_pop = err_pop + PC_W'(err_bits[i]);
    end
    cnt_sum = SUM_W'(err_cnt_q) + SUM_W'(err_pop);
    cnt_sat = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
  end

  // Checker FSM and counters.
  always_comb begin
    hist_d     = hist_q;
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    loss_cnt_d = loss_cnt_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (mode_chg) begin
      hist_d     = '0;
      state_d    = ST_HUNT;
      sync_cnt_d = '0;
      loss_cnt_d = '0;
    end else if (rx_valid) begin
      hist_d     = hist_next;
      err_flag_d = word_err;
      if (state_q == ST_LOCKED) begin
        err_cnt_d = cnt_sat;
      end
      case (state_q)
        ST_HUNT: begin
          if (!word_err) begin
            sync_cnt_d = SC_W'(1);
            state_d    = (SYNC_N <= 1) ? ST_LOCKED : ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (word_err) begin
            state_d    = ST_HUNT;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + SC_W'(1);
            if (int'(sync_cnt_q) + 1 >= SYNC_N) begin
              state_d    = ST_LOCKED;
              loss_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (word_err) begin
            if (int'(loss_cnt_q) + 1 >= LOSS_N) begin
              state_d    = ST_HUNT;
              loss_cnt_d = '0;
              sync_cnt_d = '0;
            end else begin
              loss_cnt_d = loss_cnt_q + LC_W'(1);
            end
          end else begin
            loss_cnt_d = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
    if (clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mode_q     <= MODE_PRBS7;
      gen_q      <= LFSR_SEED;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      inj_pend_q <= 1'b0;
      hist_q     <= '0;
      state_q    <= ST_HUNT;
      sync_cnt_q <= '0;
      loss_cnt_q <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      gen_q      <= gen_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      inj_pend_q <= inj_pend_d;
      hist_q     <= hist_d;
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign locked   = (state_q == ST_LOCKED);
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - randomized loopback bench with a bit-level reference model
module tb_prbs_gen_chk;

  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       mode;
  logic             gen_en, inject_err, rx_valid, clr_cnt;
  logic [W-1:0]     rx_data;
  logic [W-1:0]     tx_data;
  logic             tx_valid, locked, err_flag;
  logic [CNT_W-1:0] err_cnt;

  logic        gen_en1, tx_valid1, locked1, err_flag1;
  logic [0:0]  tx_data1;
  logic [15:0] err_cnt1;

  prbs_gen_chk #(.W(W), .CNT_W(CNT_W), .SYNC_N(16), .LOSS_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .gen_en(gen_en), .inject_err(inject_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .rx_data(rx_data), .rx_valid(rx_valid),
    .clr_cnt(clr_cnt), .locked(locked), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  prbs_gen_chk #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(2'd0), .gen_en(gen_en1), .inject_err(1'b0),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .rx_data(1'b0), .rx_valid(1'b0),
    .clr_cnt(1'b0), .locked(locked1), .err_flag(err_flag1), .err_cnt(err_cnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bit histories in queues, newest bit at the back.
  bit         gh[$];
  bit         rh[$];
  int         m_st, m_good, m_bad, m_cnt;
  logic       m_flag, m_tx_valid, m_inj_pend;
  logic [7:0] m_tx_data;
  logic [1:0] m_prev;

  function automatic int ord(input logic [1:0] m);
    case (m)
      2'd0: return 7;
      2'd1: return 15;
      2'd2: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int tapn(input logic [1:0] m);
    case (m)
      2'd0: return 6;
      2'd1: return 14;
      2'd2: return 18;
      default: return 28;
    endcase
  endfunction

  function automatic bit lag(input int l);
    return (rh.size() >= l) ? rh[rh.size() - l] : 1'b0;
  endfunction

  task automatic model_reset();
    gh.delete();
    repeat (31) gh.push_back(1'b1);
    rh.delete();
    m_st = 0; m_good = 0; m_bad = 0; m_cnt = 0;
    m_flag = 0; m_tx_valid = 0; m_tx_data = '0; m_inj_pend = 0; m_prev = 2'd0;
  endtask

  task automatic model_step(input logic g, input logic inj, input logic rv,
                            input logic [7:0] rd, input logic clr, input logic [1:0] md);
    int n, t, errs;
    logic pend;
    bit nb, e;
    logic [7:0] w;
    n = ord(md);
    t = tapn(md);
    pend = m_inj_pend | inj;
    if (md != m_prev) begin
      gh.delete();
      repeat (31) gh.push_back(1'b1);
      rh.delete();
      m_st = 0; m_good = 0; m_bad = 0;
      m_tx_valid = 0;
      m_inj_pend = pend;
    end else begin
      if (g) begin
        w = '0;
        for (int i = W - 1; i >= 0; i--) begin
          nb = gh[gh.size() - n] ^ gh[gh.size() - t];
          gh.push_back(nb);
          if (gh.size() > 40) void'(gh.pop_front());
          w[i] = nb;
        end
        if (pend) w[W-1] = ~w[W-1];
        m_tx_data = w; m_tx_valid = 1; m_inj_pend = 0;
      end else begin
        m_tx_valid = 0; m_inj_pend = pend;
      end
      if (rv) begin
        errs = 0;
        for (int i = W - 1; i >= 0; i--) begin
          e = lag(n) ^ lag(t);
          if (rd[i] != e) errs++;
          rh.push_back(rd[i]);
          if (rh.size() > 40) void'(rh.pop_front());
        end
        m_flag = (errs != 0);
        if (m_st == 2) m_cnt = (m_cnt + errs > SAT) ? SAT : m_cnt + errs;
        if (errs == 0) begin
          case (m_st)
            0: begin m_good = 1; m_st = 1; end
            1: begin m_good++; if (m_good >= 16) begin m_st = 2; m_bad = 0; end end
            default: m_bad = 0;
          endcase
        end else begin
          case (m_st)
            0: ;
            1: begin m_st = 0; m_good = 0; end
            default: begin
              m_bad++;
              if (m_bad >= 4) begin m_st = 0; m_bad = 0; m_good = 0; end
            end
          endcase
        end
      end
    end
    if (clr) m_cnt = 0;
    m_prev = md;
  endtask

  // One cycle, entered and left at a falling edge. rxsel: 0 loopback,
  // 1 forced word, 2 loopback xor rxw.
  task automatic cyc(input logic g, input logic inj, input int rxsel,
                     input logic [7:0] rxw, input logic clr, input logic [1:0] md);
    logic       rv;
    logic [7:0] rd;
    check("tx_valid", tx_valid, m_tx_valid);
    if (m_tx_valid) check("tx_data", tx_data, m_tx_data);
    check("locked", locked, (m_st == 2));
    check("err_flag", err_flag, m_flag);
    check("err_cnt", err_cnt, m_cnt);
    case (rxsel)
      1:       begin rd = rxw; rv = 1'b1; end
      2:       begin rd = tx_data ^ rxw; rv = tx_valid; end
      default: begin rd = tx_data; rv = tx_valid; end
    endcase
    gen_en = g; inject_err = inj; rx_data = rd; rx_valid = rv; clr_cnt = clr; mode = md;
    model_step(g, inj, rv, rd, clr, md);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lock_wait(input logic [1:0] md, input string tag);
    int   words, guard;
    logic g;
    words = 0;
    guard = 0;
    while (!locked && words < 40 && guard < 300) begin
      g = ($urandom_range(0, 3) != 0);
      if (tx_valid) words++;
      guard++;
      cyc(g, 1'b0, 0, 8'h00, 1'b0, md);
    end
    check(tag, locked, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_flag"}, err_flag, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   ref1[300];
    bit   got1[$];
    int   guard, perr, ones, serr;
    logic [6:0] first7;

    rst_n = 1'b1; mode = 2'd0; gen_en = 0; inject_err = 0; rx_valid = 0;
    rx_data = '0; clr_cnt = 0; gen_en1 = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_w1_tx_valid", tx_valid1, 0);
    check("reset_w1_tx_data", tx_data1, 0);
    check("reset_w1_locked", locked1, 0);
    check("reset_w1_err_cnt", err_cnt1, 0);
    rst_n = 1'b0;
    @(negedge clk);

    // PRBS7, one bit per clock, from the all-ones seed.
    for (int k = 0; k < 300; k++) begin
      bit a, b;
      a = (k >= 7) ? ref1[k-7] : 1'b1;
      b = (k >= 6) ? ref1[k-6] : 1'b1;
      ref1[k] = a ^ b;
    end
    gen_en1 = 1'b1;
    @(negedge clk);
    check("w1_valid_latency", tx_valid1, 1);
    guard = 0;
    while (got1.size() < 254 && guard < 400) begin
      if (tx_valid1) got1.push_back(tx_data1[0]);
      guard++;
      if (got1.size() < 254) @(negedge clk);
    end
    check("w1_collected", got1.size(), 254);
    gen_en1 = 1'b0;
    @(negedge clk);
    check("w1_valid_off", tx_valid1, 0);
    gen_en1 = 1'b1;
    @(negedge clk);
    check("w1_resume_bit", tx_data1, ref1[254]);
    gen_en1 = 1'b0;
    if (got1.size() == 254) begin
      for (int k = 0; k < 7; k++) first7[6-k] = got1[k];
      check("prbs7_first7", first7, 7'b0000001);
      perr = 0; ones = 0; serr = 0;
      for (int k = 0; k < 127; k++) begin
        if (got1[k] != got1[k+127]) perr++;
        if (got1[k]) ones++;
      end
      for (int k = 0; k < 254; k++) if (got1[k] != ref1[k]) serr++;
      check("prbs7_period", perr, 0);
      check("prbs7_ones", ones, 64);
      check("prbs7_seq", serr, 0);
    end
    @(negedge clk);

    // PRBS31 loopback: lock, then long clean run.
    lock_wait(2'd3, "lock_prbs31");
    repeat (2000) cyc(($urandom_range(0, 3) != 0), 1'b0, 0, 8'h00, 1'b0, 2'd3);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_locked", locked, 1);

    // Single injected error: the bit plus its two tap echoes.
    cyc(1'b1, 1'b1, 0, 8'h00, 1'b0, 2'd3);
    repeat (60) cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd3);
    check("inject_err_cnt", err_cnt, 3);
    check("inject_locked", locked, 1);
    cyc(1'b1, 1'b0, 0, 8'h00, 1'b1, 2'd3);
    check("clr_cnt", err_cnt, 0);

    // Errors spaced so lock holds, driving the counter into saturation.
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b1, 0, 8'h00, 1'b0, 2'd3);
      repeat (3) cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd3);
    end
    repeat (10) cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd3);
    check("sat_cnt", err_cnt, SAT);
    check("sat_locked", locked, 1);
    cyc(1'b1, 1'b0, 2, 8'h01, 1'b1, 2'd3);
    check("clr_priority", err_cnt, 0);
    repeat (10) cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd3);

    // Forced all-ones words drop lock; loopback relocks.
    repeat (8) cyc(1'b1, 1'b0, 1, 8'hFF, 1'b0, 2'd3);
    check("ff_unlock", locked, 0);
    lock_wait(2'd3, "relock_prbs31");
    repeat (20) cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd3);

    // Mode 3 -> 0 mid-stream.
    cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd0);
    check("mode_hunt", locked, 0);
    cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd0);
    check("prbs7_restart_valid", tx_valid, 1);
    check("prbs7_restart_word", tx_data, 8'h02);
    lock_wait(2'd0, "relock_prbs7");
    repeat (50) cyc(($urandom_range(0, 1) != 0), 1'b0, 0, 8'h00, 1'b0, 2'd0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lock_wait(2'd0, "lock_after_reset");
    repeat (30) cyc(1'b1, 1'b0, 0, 8'h00, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
